// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline front end.
package arm_pipe_pkg;

    localparam int XLEN = 32;

    // MOV r0,r0 is the canonical ARM no-op presented whenever no instruction is valid
    localparam logic [XLEN-1:0] INST_NOP = 32'hE1A0_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} pairs between instruction memory and IF/ID.
module fetch_buffer
    import arm_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // DEPTH is a power of two, so the pointers wrap naturally
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // The fetch stage only issues when a slot is reserved for the returning word
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_stage.sv
// ARM fetch stage: owns the PC, reads a 1-cycle-latency instruction memory and
// buffers returned words so IF/ID stalls never drop an in-flight fetch.
module fetch_stage
    import arm_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
    parameter int              FIFO_DEPTH = 2,
    localparam int             CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            inst_valid
);

    logic [XLEN-1:0] pc_q;
    logic            inflight_q;
    logic            issue;
    logic            pop;
    logic            push;
    logic [CW:0]     occupancy;
    logic [CW:0]     limit;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;

    // Issue only if the word will still have a slot after this edge's pop
    assign occupancy  = {1'b0, count} + (CW + 1)'(inflight_q);
    assign limit      = (CW + 1)'(FIFO_DEPTH) + (CW + 1)'(pop);
    assign inst_valid = ~rst & ~empty & ~branch_taken;
    assign pop        = inst_valid & ~stall;
    assign issue      = ~rst & ~branch_taken & (occupancy < limit);
    assign push       = inflight_q & ~branch_taken;

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    // pc_q advanced by exactly one word when the returning request was issued
    assign wr_entry.pc   = pc_q - XLEN'(4);
    assign wr_entry.inst = imem_rdata;

    assign inst_out = inst_valid ? head.inst : INST_NOP;
    assign pc_out   = inst_valid ? head.pc   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else if (branch_taken) begin
            pc_q       <= {branch_target[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) pc_q <= pc_q + XLEN'(4);
        end
    end

    fetch_buffer #(
        .DEPTH(FIFO_DEPTH)
    ) u_fetch_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_taken),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a queue-based fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] instOut;
    logic [31:0] pcOut;
    logic        instValid;

    logic        stall2 = 1'b0;
    logic        branch2 = 1'b0;
    logic [31:0] target2 = 32'h0;
    logic        imemReq2;
    logic [31:0] imemAddr2;
    logic [31:0] imemRdata2;
    logic [31:0] instOut2;
    logic [31:0] pcOut2;
    logic        instValid2;

    int testCount = 0;
    int failCount = 0;

    // Reference model: queue of buffered addresses plus at most one outstanding request
    logic [31:0] mq[$];
    int          mInfl;
    logic [31:0] mInflAddr;
    logic [31:0] mPc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branchTaken),
        .branch_target(branchTarget), .imem_req(imemReq), .imem_addr(imemAddr),
        .imem_rdata(imemRdata), .inst_out(instOut), .pc_out(pcOut), .inst_valid(instValid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dutWrap (
        .clk(clk), .rst(rst), .stall(stall2), .branch_taken(branch2),
        .branch_target(target2), .imem_req(imemReq2), .imem_addr(imemAddr2),
        .imem_rdata(imemRdata2), .inst_out(instOut2), .pc_out(pcOut2), .inst_valid(instValid2)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        imemRdata  <= rom(imemAddr);
        imemRdata2 <= rom(imemAddr2);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        stall        = st;
        branchTaken  = br;
        branchTarget = tgt;
    endtask

    task automatic midReset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_req", {31'b0, imemReq}, 32'd0);
        checkOutput("midrst_valid", {31'b0, instValid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Advance the model on every clock edge from the stimulus the DUT also sees
    always @(posedge clk or posedge rst) begin : modelStep
        int   occ;
        logic mPop;
        if (rst) begin
            mq.delete();
            mInfl = 0;
            mInflAddr = 32'h0;
            mPc = 32'h0;
        end else if (branchTaken) begin
            mq.delete();
            mInfl = 0;
            mPc = {branchTarget[31:2], 2'b00};
        end else begin
            mPop = (mq.size() > 0) && !stall;
            occ = mq.size() + mInfl - (mPop ? 1 : 0);
            if (mPop) void'(mq.pop_front());
            if (mInfl != 0) mq.push_back(mInflAddr);
            if (mq.size() > 2) checkOutput("model_overflow", mq.size(), 2);
            if (occ < 2) begin
                mInfl = 1;
                mInflAddr = mPc;
                mPc = mPc + 32'd4;
            end else begin
                mInfl = 0;
            end
        end
    end

    // Compare every cycle away from the active edge
    always @(negedge clk) begin : compare
        logic        expValid;
        logic        expReq;
        logic [31:0] expPc;
        int          popN;
        if (rst) begin
            checkOutput("rst_req", {31'b0, imemReq}, 32'd0);
            checkOutput("rst_valid", {31'b0, instValid}, 32'd0);
            checkOutput("rst_inst", instOut, 32'hE1A0_0000);
            checkOutput("rst_pc", pcOut, 32'd0);
        end else begin
            expValid = (mq.size() > 0) && !branchTaken;
            expPc    = expValid ? mq[0] : 32'h0;
            popN     = (expValid && !stall) ? 1 : 0;
            expReq   = !branchTaken && (mq.size() + mInfl - popN < 2);
            checkOutput("valid", {31'b0, instValid}, {31'b0, expValid});
            checkOutput("pc_out", pcOut, expPc);
            checkOutput("inst_out", instOut, expValid ? rom(expPc) : 32'hE1A0_0000);
            checkOutput("imem_req", {31'b0, imemReq}, {31'b0, expReq});
            checkOutput("imem_addr", imemAddr, mPc);
        end
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        branchTaken = 1'b0;
        branchTarget = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Startup stream from both reset vectors, including the wrap past FFFF_FFFC
        @(negedge clk);
        checkOutput("c0_addr", imemAddr, 32'h0);
        checkOutput("c0_valid", {31'b0, instValid}, 32'd0);
        checkOutput("w0_addr", imemAddr2, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("c1_addr", imemAddr, 32'h4);
        checkOutput("c1_valid", {31'b0, instValid}, 32'd0);
        checkOutput("w1_addr", imemAddr2, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("c2_valid", {31'b0, instValid}, 32'd1);
        checkOutput("c2_pc", pcOut, 32'h0);
        checkOutput("c2_inst", instOut, 32'h1000_0000);
        checkOutput("w2_addr", imemAddr2, 32'h0);
        checkOutput("w2_pc", pcOut2, 32'hFFFF_FFF8);
        checkOutput("w2_inst", instOut2, 32'h4FFF_FFFE);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("c3_pc", pcOut, 32'h4);
        checkOutput("c3_inst", instOut, 32'h1000_0001);
        checkOutput("w3_pc", pcOut2, 32'hFFFF_FFFC);

        // Five stall cycles fill the buffer and freeze the PC
        repeat (5) applyStimulus(1, 0, 0);
        @(negedge clk);
        checkOutput("s5_req", {31'b0, imemReq}, 32'd0);
        checkOutput("s5_pc", pcOut, 32'h8);
        checkOutput("s5_addr", imemAddr, 32'h10);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("r1_pc", pcOut, 32'h8);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("r2_pc", pcOut, 32'hC);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("r3_pc", pcOut, 32'h10);

        // Redirect with a full buffer and stall asserted in the same cycle
        repeat (2) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 32'h0000_0103);
        @(negedge clk);
        checkOutput("br_valid", {31'b0, instValid}, 32'd0);
        checkOutput("br_req", {31'b0, imemReq}, 32'd0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("b1_addr", imemAddr, 32'h100);
        checkOutput("b1_valid", {31'b0, instValid}, 32'd0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("b2_valid", {31'b0, instValid}, 32'd0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("b3_pc", pcOut, 32'h100);
        checkOutput("b3_inst", instOut, 32'h1000_0040);

        // Asynchronous reset between edges, then restart from the reset vector
        repeat (3) applyStimulus(0, 0, 0);
        midReset();
        @(negedge clk);
        checkOutput("rr_addr", imemAddr, 32'h0);
        checkOutput("rr_valid", {31'b0, instValid}, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            logic        st;
            logic        br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
            applyStimulus(st, br, tgt);
            if (i % 500 == 499) begin
                applyStimulus(0, 0, 0);
                midReset();
            end
        end

        applyStimulus(0, 0, 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
